// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file: CSRRW/RS/RC, ecall and timer traps, mret,
// mcycle/minstret and the fetch redirect for trap entry and return.
module csr_trap_unit #(
  parameter int unsigned XLEN = 64,
  parameter logic [63:0] MSTATUS_RESET = 64'h0000_000a_0000_1800,
  parameter logic [63:0] MTVEC_RESET = 64'h0,
  parameter bit HAS_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_src,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            ecall,
  input  logic            mret,
  input  logic            instr_retire,
  input  logic            timer_irq,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // MIE/MPIE live in flops; MPP reads 2'b11; the rest is reset value
  localparam logic [XLEN-1:0] MST_RST = MSTATUS_RESET[XLEN-1:0];
  localparam logic [XLEN-1:0] MST_DYN = XLEN'(64'h1888);
  localparam logic [XLEN-1:0] MST_FIX =
    (MST_RST & ~MST_DYN) | XLEN'(64'h1800);

  localparam logic [XLEN-1:0] TVEC_RST = MTVEC_RESET[XLEN-1:0];
  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, (XLEN-1)'(7)};
  localparam logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11);
  localparam logic [XLEN-1:0] IRQ_OFFS = XLEN'(28);

  logic            mst_mie;
  logic            mst_mpie;
  logic            mie_mtie;
  logic            mip_mtip;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] tvec_wd;
  logic [XLEN-1:0] tvec_base;

  logic sel_mstatus;
  logic sel_mie;
  logic sel_mtvec;
  logic sel_mscratch;
  logic sel_mepc;
  logic sel_mcause;
  logic sel_mip;
  logic sel_mcycle;
  logic sel_minstret;
  logic sel_mhartid;
  logic supported;

  logic op_any;
  logic no_write;
  logic irq_take;
  logic ecall_take;
  logic trap;
  logic mret_take;
  logic csr_we;

  assign sel_mstatus  = (csr_addr == A_MSTATUS);
  assign sel_mie      = (csr_addr == A_MIE);
  assign sel_mtvec    = (csr_addr == A_MTVEC);
  assign sel_mscratch = (csr_addr == A_MSCRATCH);
  assign sel_mepc     = (csr_addr == A_MEPC);
  assign sel_mcause   = (csr_addr == A_MCAUSE);
  assign sel_mip      = (csr_addr == A_MIP);
  assign sel_mcycle   = (csr_addr == A_MCYCLE);
  assign sel_minstret = (csr_addr == A_MINSTRET);
  assign sel_mhartid  = (csr_addr == A_MHARTID);

  always_comb begin
    mstatus_rd = MST_FIX;
    mstatus_rd[3] = mst_mie;
    mstatus_rd[7] = mst_mpie;
  end

  always_comb begin
    csr_rdata = '0;
    supported = 1'b1;
    unique case (1'b1)
      sel_mstatus:  csr_rdata = mstatus_rd;
      sel_mie:      csr_rdata[7] = mie_mtie;
      sel_mtvec:    csr_rdata = mtvec;
      sel_mscratch: csr_rdata = mscratch;
      sel_mepc:     csr_rdata = mepc;
      sel_mcause:   csr_rdata = mcause;
      sel_mip:      csr_rdata[7] = mip_mtip;
      sel_mcycle:   csr_rdata = mcycle;
      sel_minstret: csr_rdata = minstret;
      sel_mhartid:  csr_rdata = '0;
      default:      supported = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op)
      OP_RW:   wdata = csr_src;
      OP_RS:   wdata = csr_rdata | csr_src;
      OP_RC:   wdata = csr_rdata & ~csr_src;
      default: wdata = csr_rdata;
    endcase
  end

  // MODE values 2 and 3 are reserved and collapse to direct mode
  always_comb begin
    tvec_wd = wdata;
    if (wdata[1]) tvec_wd[1:0] = 2'b00;
  end

  assign tvec_base = {mtvec[XLEN-1:2], 2'b00};

  assign op_any   = (csr_op != OP_NONE);
  assign no_write = (csr_op != OP_RW) && (csr_src == '0);

  assign csr_illegal = instr_valid && op_any &&
    (!supported ||
     (sel_mhartid && ((csr_op == OP_RW) || (csr_src != '0))));

  assign irq_take   = instr_valid && mst_mie && mie_mtie && mip_mtip;
  assign ecall_take = instr_valid && ecall && !irq_take;
  assign trap       = irq_take || ecall_take;
  assign mret_take  = instr_valid && mret && !ecall && !irq_take;

  assign csr_we = instr_valid && op_any && !csr_illegal &&
    !trap && !mret_take && !no_write;

  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if (rst_n && trap) begin
      redirect_valid = 1'b1;
      redirect_pc = tvec_base;
      if (irq_take && (mtvec[1:0] == 2'b01))
        redirect_pc = tvec_base + IRQ_OFFS;
    end else if (rst_n && mret_take) begin
      redirect_valid = 1'b1;
      redirect_pc = mepc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mst_mie  <= MST_RST[3];
      mst_mpie <= MST_RST[7];
      mie_mtie <= 1'b0;
      mip_mtip <= 1'b0;
      mtvec    <= TVEC_RST;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      mip_mtip <= timer_irq;
      if (trap) begin
        mepc     <= pc;
        mcause   <= irq_take ? IRQ_CAUSE : ECALL_CAUSE;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (mret_take) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (csr_we) begin
        unique case (1'b1)
          sel_mstatus: begin
            mst_mie  <= wdata[3];
            mst_mpie <= wdata[7];
          end
          sel_mie:      mie_mtie <= wdata[7];
          sel_mtvec:    mtvec <= tvec_wd;
          sel_mscratch: mscratch <= wdata;
          sel_mepc:     mepc <= {wdata[XLEN-1:2], 2'b00};
          sel_mcause:   mcause <= wdata;
          default: ;
        endcase
      end
    end
  end

  // a same-cycle CSR write takes precedence over the increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else if (HAS_COUNTERS) begin
      if (csr_we && sel_mcycle)
        mcycle <= wdata;
      else
        mcycle <= mcycle + XLEN'(1);
      if (csr_we && sel_minstret)
        minstret <= wdata;
      else if (instr_retire)
        minstret <= minstret + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: stimulus queues expected responses,
// a negedge monitor pops and compares them.
module tb_csr_trap_unit;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [63:0] pc;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_src;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        ecall;
  logic        mret;
  logic        instr_retire;
  logic        timer_irq;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [63:0] rd;
    logic        ill;
    logic        rv;
    logic [63:0] rpc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rst_v = 1'b0;
  bit   irq_v = 1'b0;

  localparam logic [63:0] MS = 64'h0000_000a_0000_1800;
  localparam logic [63:0] ONES = '1;

  csr_trap_unit #(
    .XLEN(64),
    .MSTATUS_RESET(64'h0000_000a_0000_1800),
    .MTVEC_RESET(64'h0),
    .HAS_COUNTERS(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_valid(instr_valid),
    .pc(pc),
    .csr_op(csr_op),
    .csr_addr(csr_addr),
    .csr_src(csr_src),
    .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal),
    .ecall(ecall),
    .mret(mret),
    .instr_retire(instr_retire),
    .timer_irq(timer_irq),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input bit v,
                      input logic [63:0] p, input logic [1:0] op,
                      input logic [11:0] a, input logic [63:0] s,
                      input bit ec, input bit mr, input bit ret,
                      input bit crd, input logic [63:0] erd,
                      input bit eill, input bit erv,
                      input logic [63:0] erpc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst_v;
    timer_irq = irq_v;
    instr_valid = v;
    pc = p;
    csr_op = op;
    csr_addr = a;
    csr_src = s;
    ecall = ec;
    mret = mr;
    instr_retire = ret;
    e.name = nm;
    e.chk_rd = crd;
    e.rd = erd;
    e.ill = eill;
    e.rv = erv;
    e.rpc = erpc;
    q.push_back(e);
  endtask

  task automatic rd(input string nm, input logic [11:0] a,
                    input logic [63:0] e);
    step(nm, 0, 64'h0, 2'b00, a, 64'h0, 0, 0, 0, 1, e, 0, 0, 64'h0);
  endtask

  task automatic cw(input string nm, input logic [1:0] op,
                    input logic [11:0] a, input logic [63:0] s,
                    input logic [63:0] eold, input bit eill);
    step(nm, 1, 64'h8000_0000, op, a, s, 0, 0, 0, 1, eold, eill,
         0, 64'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".redirect_valid"}, 64'(redirect_valid),
            64'(e.rv));
        chk({e.name, ".csr_illegal"}, 64'(csr_illegal), 64'(e.ill));
        if (e.chk_rd)
          chk({e.name, ".csr_rdata"}, csr_rdata, e.rd);
        if (e.rv)
          chk({e.name, ".redirect_pc"}, redirect_pc, e.rpc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0;
    instr_valid = 1'b0;
    pc = '0;
    csr_op = '0;
    csr_addr = '0;
    csr_src = '0;
    ecall = 1'b0;
    mret = 1'b0;
    instr_retire = 1'b0;
    timer_irq = 1'b0;

    step("rst_ecall", 1, 64'h8000_0000, 2'b00, 12'h300, 64'h0,
         1, 0, 0, 0, 64'h0, 0, 0, 64'h0);
    step("rst_idle", 0, 64'h0, 2'b00, 12'h300, 64'h0,
         0, 0, 0, 0, 64'h0, 0, 0, 64'h0);
    rst_v = 1'b1;
    rd("mstatus_rst", 12'h300, MS);
    rd("mhartid", 12'hF14, 64'h0);
    rd("mcycle_n", 12'hB00, 64'd2);

    cw("w_mtvec", 2'b01, 12'h305, 64'h8000_1000, 64'h0, 0);
    rd("mtvec", 12'h305, 64'h8000_1000);
    cw("rs_mie", 2'b10, 12'h300, 64'h8, MS, 0);
    rd("mstatus_mie1", 12'h300, MS | 64'h8);
    cw("rc_mie", 2'b11, 12'h300, 64'h8, MS | 64'h8, 0);
    rd("mstatus_mie0", 12'h300, MS);
    cw("rs_mie2", 2'b10, 12'h300, 64'h8, MS, 0);

    step("ecall", 1, 64'h8000_0100, 2'b00, 12'h300, 64'h0,
         1, 0, 0, 1, MS | 64'h8, 0, 1, 64'h8000_1000);
    rd("mepc_ecall", 12'h341, 64'h8000_0100);
    rd("mcause_ecall", 12'h342, 64'd11);
    rd("mstatus_ecall", 12'h300, MS | 64'h80);
    step("mret", 1, 64'h8000_0180, 2'b00, 12'h300, 64'h0,
         0, 1, 0, 1, MS | 64'h80, 0, 1, 64'h8000_0100);
    rd("mstatus_mret", 12'h300, MS | 64'h88);

    step("ecall_mret", 1, 64'h8000_0200, 2'b00, 12'h300, 64'h0,
         1, 1, 0, 0, 64'h0, 0, 1, 64'h8000_1000);
    rd("mepc_em", 12'h341, 64'h8000_0200);
    step("mret2", 1, 64'h8000_0204, 2'b00, 12'h300, 64'h0,
         0, 1, 0, 1, MS | 64'h80, 0, 1, 64'h8000_0200);

    cw("w_mepc", 2'b01, 12'h341, 64'h8000_0107, 64'h8000_0200, 0);
    rd("mepc_align", 12'h341, 64'h8000_0104);
    cw("w_mtvec3", 2'b01, 12'h305, 64'h8000_1003, 64'h8000_1000, 0);
    rd("mtvec_warl", 12'h305, 64'h8000_1000);
    cw("w_mtvec1", 2'b01, 12'h305, 64'h8000_1001, 64'h8000_1000, 0);
    rd("mtvec_vec", 12'h305, 64'h8000_1001);
    cw("w_mie", 2'b01, 12'h304, ONES, 64'h0, 0);
    rd("mie_mask", 12'h304, 64'h80);

    irq_v = 1'b1;
    rd("mip_lat", 12'h344, 64'h0);
    rd("mip_set", 12'h344, 64'h80);
    step("irq", 1, 64'h8000_0300, 2'b01, 12'h340, 64'h1234,
         0, 0, 0, 1, 64'h0, 0, 1, 64'h8000_101C);
    irq_v = 1'b0;
    step("irq_masked", 1, 64'h8000_0304, 2'b00, 12'h342, 64'h0,
         0, 0, 0, 1, 64'h8000_0000_0000_0007, 0, 0, 64'h0);
    rd("mscratch_supp", 12'h340, 64'h0);
    rd("mepc_irq", 12'h341, 64'h8000_0300);
    rd("mstatus_irq", 12'h300, MS | 64'h80);

    cw("ill_7c0", 2'b01, 12'h7C0, 64'h5, 64'h0, 1);
    cw("ill_hart_rw", 2'b01, 12'hF14, 64'h1, 64'h0, 1);
    cw("hart_rs0", 2'b10, 12'hF14, 64'h0, 64'h0, 0);
    cw("ill_hart_rc", 2'b11, 12'hF14, 64'h3, 64'h0, 1);

    step("w_mcycle", 1, 64'h8000_0000, 2'b01, 12'hB00, ONES,
         0, 0, 0, 0, 64'h0, 0, 0, 64'h0);
    rd("mcycle_max", 12'hB00, ONES);
    rd("mcycle_wrap", 12'hB00, 64'h0);

    step("w_minstret", 1, 64'h8000_0000, 2'b01, 12'hB02, 64'd100,
         0, 0, 1, 1, 64'h0, 0, 0, 64'h0);
    rd("minstret_w", 12'hB02, 64'd100);
    step("retire", 0, 64'h0, 2'b00, 12'hB02, 64'h0,
         0, 0, 1, 1, 64'd100, 0, 0, 64'h0);
    rd("minstret_inc", 12'hB02, 64'd101);

    cw("w_mscratch", 2'b01, 12'h340, 64'hAA, 64'h0, 0);
    cw("rc_zero", 2'b11, 12'h340, 64'h0, 64'hAA, 0);
    rd("mscratch", 12'h340, 64'hAA);
    cw("w_mip", 2'b01, 12'h344, 64'h80, 64'h0, 0);
    rd("mip_ro", 12'h344, 64'h0);

    rst_v = 1'b0;
    step("rst_trap", 1, 64'h8000_0400, 2'b00, 12'h300, 64'h0,
         1, 0, 0, 0, 64'h0, 0, 0, 64'h0);
    rst_v = 1'b1;
    rd("mstatus_rst2", 12'h300, MS);
    rd("mtvec_rst2", 12'h305, 64'h0);
    rd("mepc_rst2", 12'h341, 64'h0);
    rd("minstret_rst2", 12'hB02, 64'h0);
    rd("mscratch_rst2", 12'h340, 64'h0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
